// File: rtl/booth_mult_unit_pkg.sv
// Shared constants for the sequential Booth multiplier used by the MULT instruction.
package booth_mult_unit_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_STEPS = 32;

    localparam logic [1:0] ST_M_IDLE = 2'b00;
    localparam logic [1:0] ST_M_RUN  = 2'b01;
    localparam logic [1:0] ST_M_DONE = 2'b10;

    // Booth recoding of {multiplier lsb, previously shifted-out bit}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_unit_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into the upper accumulator,
// then an arithmetic right shift of {p_hi, p_lo, q_1}.
module booth_mult_unit_step
    import booth_mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   p_hi,
    input  logic [WIDTH-1:0] p_lo,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   p_hi_c,
    output logic [WIDTH-1:0] p_lo_c,
    output logic             q_1_c
);

    logic [WIDTH:0] acc;

    always_comb begin
        acc = p_hi;
        case ({p_lo[0], q_1})
            BOOTH_ADD: acc = p_hi + m;
            BOOTH_SUB: acc = p_hi - m;
            default:   acc = p_hi;
        endcase
        // Sign bit of the extended accumulator is replicated into the vacated msb
        p_hi_c = {acc[WIDTH], acc[WIDTH:1]};
        p_lo_c = {acc[0], p_lo[WIDTH-1:1]};
        q_1_c  = p_lo[0];
    end

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential signed WIDTHxWIDTH multiplier for MULT: one Booth step per clock,
// result latched into HI/LO with a single-cycle mult_end pulse.
module booth_mult_unit
    import booth_mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned STEPS = MULT_STEPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             mult_end,
    output logic             busy
);

    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   p_hi_q;
    logic [WIDTH-1:0] p_lo_q;
    logic             q_1_q;

    logic [WIDTH:0]   p_hi_c;
    logic [WIDTH-1:0] p_lo_c;
    logic             q_1_c;
    logic             last_step_c;
    logic             start_c;

    booth_mult_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_hi   (p_hi_q),
        .p_lo   (p_lo_q),
        .q_1    (q_1_q),
        .m      (m_q),
        .p_hi_c (p_hi_c),
        .p_lo_c (p_lo_c),
        .q_1_c  (q_1_c)
    );

    assign last_step_c = (count_q == CNT_W'(STEPS - 1));
    assign start_c     = (state_q == ST_M_IDLE) && mult_control;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_M_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start requests outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_M_IDLE: if (mult_control) state_d = ST_M_RUN;
            ST_M_RUN:  if (last_step_c)  state_d = ST_M_DONE;
            ST_M_DONE: state_d = ST_M_IDLE;
            default:   state_d = ST_M_IDLE;
        endcase
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            m_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            q_1_q    <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            mult_end <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy     <= (state_d != ST_M_IDLE);
            mult_end <= (state_q == ST_M_RUN) && last_step_c;
            if (start_c) begin
                m_q     <= {A[WIDTH-1], A};
                p_hi_q  <= '0;
                p_lo_q  <= B;
                q_1_q   <= 1'b0;
                count_q <= '0;
            end else if (state_q == ST_M_RUN) begin
                p_hi_q  <= p_hi_c;
                p_lo_q  <= p_lo_c;
                q_1_q   <= q_1_c;
                count_q <= count_q + CNT_W'(1);
                if (last_step_c) begin
                    HI <= p_hi_c[WIDTH-1:0];
                    LO <= p_lo_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed + random bench for booth_mult_unit against a plain signed-multiply model.
module tb_booth_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_control;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        mult_end;
    logic        busy;

    int errors = 0;
    int checks = 0;

    booth_mult_unit #(
        .WIDTH (32),
        .STEPS (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mult_control (mult_control),
        .A            (A),
        .B            (B),
        .HI           (HI),
        .LO           (LO),
        .mult_end     (mult_end),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full operation: start, scramble inputs, check latency, product and return to idle
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        logic [63:0] exp_p;
        exp_p = ref_prod(a, b);
        @(negedge clk);
        A = a;
        B = b;
        mult_control = 1'b1;
        cycle();
        mult_control = 1'b0;
        A = $urandom;
        B = $urandom;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (mult_end) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd32);
        check({tag, " product"}, {HI, LO}, exp_p);
        cycle();
        check({tag, " end_low"}, 64'(mult_end), 64'd0);
        check({tag, " busy_low"}, 64'(busy), 64'd0);
        check({tag, " product_held"}, {HI, LO}, exp_p);
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        mult_control = 1'b0;
        A = '0;
        B = '0;
        cycle();
        cycle();
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_end", 64'(mult_end), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        cycle();

        do_mult(32'd3, 32'd5, "3x5");
        do_mult(32'hFFFF_FFFF, 32'd1, "m1x1");
        do_mult(32'hFFFF_FFF9, 32'hFFFF_FFFA, "m7xm6");
        do_mult(32'h8000_0000, 32'h8000_0000, "minxmin");
        do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxxmax");
        do_mult(32'h8000_0000, 32'h7FFF_FFFF, "minxmax");
        do_mult(32'd0, 32'h8000_0000, "0xmin");

        // Start request while running must be ignored
        @(negedge clk);
        A = 32'd2;
        B = 32'd3;
        mult_control = 1'b1;
        cycle();
        mult_control = 1'b0;
        pulses = 0;
        first_at = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                A = 32'd9;
                B = 32'd9;
                mult_control = 1'b1;
            end else begin
                mult_control = 1'b0;
            end
            cycle();
            if (mult_end) begin
                pulses++;
                if (first_at == 0) first_at = i;
                check("ignore_product", {HI, LO}, 64'd6);
            end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_latency", 64'(first_at), 64'd32);
        do_mult(32'd9, 32'd9, "9x9");

        // Asynchronous reset mid-operation
        @(negedge clk);
        A = 32'd4;
        B = 32'd4;
        mult_control = 1'b1;
        cycle();
        mult_control = 1'b0;
        for (int i = 1; i < 15; i++) cycle();
        reset = 1'b1;
        #1;
        check("midreset_hilo", {HI, LO}, 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_end", 64'(mult_end), 64'd0);
        cycle();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (mult_end) pulses++;
        end
        check("midreset_no_end", 64'(pulses), 64'd0);
        check("midreset_idle", 64'(busy), 64'd0);
        do_mult(32'd4, 32'd4, "4x4_after_reset");

        // mult_control held high retriggers every 34 cycles
        @(negedge clk);
        A = 32'd2;
        B = 32'd2;
        mult_control = 1'b1;
        cycle();
        pulses = 0;
        first_at = 0;
        second_at = 0;
        for (int i = 1; i <= 70; i++) begin
            cycle();
            if (mult_end) begin
                pulses++;
                if (first_at == 0) first_at = i;
                else if (second_at == 0) second_at = i;
                check("hold_product", {HI, LO}, 64'd4);
            end
        end
        mult_control = 1'b0;
        check("hold_pulses", 64'(pulses), 64'd2);
        check("hold_first", 64'(first_at), 64'd32);
        check("hold_second", 64'(second_at), 64'd66);
        for (int i = 0; i < 40 && busy; i++) cycle();
        check("hold_drained", 64'(busy), 64'd0);

        // Random operands against the reference model
        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 1) ra = {1'b1, ra[30:0]};
            if (k % 4 == 2) rb = {1'b1, rb[30:0]};
            do_mult(ra, rb, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
